// File: rtl/vlsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_pkg
// Description : Shared VLSU types and widths: request record, per-transaction
//               metadata records and 4 KiB page geometry in nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
package vlsu_pkg;

    localparam int ELEN        = 64;
    localparam int PageNibbles = 8192;
    localparam int PageOffW    = 13;

    localparam int MetaAddrW = ELEN;
    localparam int MetaLenW  = 16;
    localparam int MetaCntW  = 8;
    localparam int MetaTxnW  = MetaLenW + 1 - PageOffW;
    localparam int MetaLtnW  = PageOffW + 1;
    localparam int ReqIdW    = 4;

    typedef struct packed {
        logic [ReqIdW-1:0]    reqId;
        logic                 isLoad;
        logic [MetaAddrW-1:0] baseAddr;
        logic [MetaLenW-1:0]  segNibbles;
        logic [MetaAddrW-1:0] segStride;
        logic [MetaAddrW-1:0] grpStride;
        logic [MetaCntW-1:0]  nSeg;
        logic [MetaCntW-1:0]  nGrp;
    } vmeta_req_t;

    typedef struct packed {
        logic [ReqIdW-1:0]   reqId;
        logic                isLoad;
        logic [MetaCntW-1:0] rmnSeg;
        logic [MetaCntW-1:0] rmnGrp;
    } meta_glb_t;

    typedef struct packed {
        logic [MetaAddrW-1:0] segBaseAddr;
        logic [MetaTxnW-1:0]  txnCnt;
        logic [MetaTxnW-1:0]  txnNum;
        logic [MetaLtnW-1:0]  ltN;
    } meta_seglv_t;

endpackage
`default_nettype wire

// File: rtl/vmeta_seg_calc.sv
`default_nettype none
// ============================================================================
// Module      : vmeta_seg_calc
// Description : Combinational page split of one segment: page offset and
//               length give the extra-page count and the last-page end mark.
// Revision    : 1.0 - initial release
// ============================================================================
module vmeta_seg_calc
    import vlsu_pkg::*;
#(
    parameter int LenWidth = MetaLenW
) (
    input  logic [PageOffW-1:0]          page_off_i,
    input  logic [LenWidth-1:0]          seg_nibbles_i,
    output logic [LenWidth-PageOffW:0]   txn_num_o,
    output logic [PageOffW:0]            ltn_o
);

    // One extra bit holds offset + length without overflow.
    logic [LenWidth:0] w_end;

    assign w_end     = (LenWidth+1)'(page_off_i) + (LenWidth+1)'(seg_nibbles_i)
                     - (LenWidth+1)'(1);
    assign txn_num_o = w_end[LenWidth:PageOffW];
    assign ltn_o     = {1'b0, w_end[PageOffW-1:0]} + (PageOffW+1)'(1);

endmodule
`default_nettype wire

// File: rtl/vmeta_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : vmeta_ctrl_unit
// Description : Walks a vector memory request as groups/segments/page
//               transactions, one metadata pair per transaction.
//               VMETA_FAST_SEG_EN: skip the CALC bubble between segments.
// Revision    : 1.0 - initial release
// ============================================================================
module vmeta_ctrl_unit
    import vlsu_pkg::*;
#(
    parameter int AddrWidth = ELEN,
    parameter int LenWidth  = MetaLenW,
    parameter int CntWidth  = MetaCntW
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  vmeta_req_t  req_i,
    output logic        meta_valid_o,
    input  logic        meta_ready_i,
    output meta_glb_t   meta_glb_o,
    output meta_seglv_t meta_seglv_o,
    output logic        busy_o
);

    localparam int TxnW = LenWidth + 1 - PageOffW;
    localparam int LtnW = PageOffW + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_EMIT = 2'd2;
`ifdef VMETA_FAST_SEG_EN
    localparam logic [1:0] c_SEG_ENTRY = c_EMIT;
`else
    localparam logic [1:0] c_SEG_ENTRY = c_CALC;
`endif

    logic [1:0]           r_state, w_state_nxt;
    logic [ReqIdW-1:0]    r_req_id;
    logic                 r_is_load;
    logic [LenWidth-1:0]  r_seg_nib;
    logic [AddrWidth-1:0] r_seg_stride, r_grp_stride;
    logic [AddrWidth-1:0] r_seg_base, r_grp_base;
    logic [CntWidth-1:0]  r_n_seg, r_rmn_seg, r_rmn_grp;
    logic [TxnW-1:0]      r_txn_cnt, r_txn_num;
    logic [LtnW-1:0]      r_ltn;

    logic                 w_accept, w_hs, w_more_txn, w_more_seg, w_load_calc;
    logic [AddrWidth-1:0] w_seg_next, w_grp_next;
    logic [PageOffW-1:0]  w_calc_off;
    logic [LenWidth-1:0]  w_calc_nib;
    logic [TxnW-1:0]      w_txn_num;
    logic [LtnW-1:0]      w_ltn;

    assign w_accept   = (r_state == c_IDLE) && req_valid_i;
    assign w_hs       = (r_state == c_EMIT) && meta_ready_i;
    assign w_more_txn = r_txn_cnt < r_txn_num;
    assign w_more_seg = (r_rmn_seg != '0) || (r_rmn_grp != '0);
    assign w_seg_next = r_seg_base + r_seg_stride;
    assign w_grp_next = r_grp_base + r_grp_stride;

`ifdef VMETA_FAST_SEG_EN
    // Split the segment that becomes current at this edge.
    assign w_calc_off  = w_accept           ? req_i.baseAddr[PageOffW-1:0] :
                         (r_rmn_seg != '0)  ? w_seg_next[PageOffW-1:0]     :
                                              w_grp_next[PageOffW-1:0];
    assign w_calc_nib  = w_accept ? req_i.segNibbles : r_seg_nib;
    assign w_load_calc = w_accept || (w_hs && !w_more_txn && w_more_seg);
`else
    assign w_calc_off  = r_seg_base[PageOffW-1:0];
    assign w_calc_nib  = r_seg_nib;
    assign w_load_calc = (r_state == c_CALC);
`endif

    vmeta_seg_calc #(
        .LenWidth (LenWidth)
    ) u_seg_calc (
        .page_off_i    (w_calc_off),
        .seg_nibbles_i (w_calc_nib),
        .txn_num_o     (w_txn_num),
        .ltn_o         (w_ltn)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (req_valid_i) w_state_nxt = c_SEG_ENTRY;
            c_CALC: w_state_nxt = c_EMIT;
            c_EMIT: if (meta_ready_i && !w_more_txn) w_state_nxt = w_more_seg ? c_SEG_ENTRY : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (r_state == c_IDLE);
        busy_o       = (r_state != c_IDLE);
        meta_valid_o = (r_state == c_EMIT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_req_id     <= '0;
            r_is_load    <= 1'b0;
            r_seg_nib    <= '0;
            r_seg_stride <= '0;
            r_grp_stride <= '0;
            r_seg_base   <= '0;
            r_grp_base   <= '0;
            r_n_seg      <= '0;
            r_rmn_seg    <= '0;
            r_rmn_grp    <= '0;
            r_txn_cnt    <= '0;
            r_txn_num    <= '0;
            r_ltn        <= '0;
        end else begin
            if (w_accept) begin
                r_req_id     <= req_i.reqId;
                r_is_load    <= req_i.isLoad;
                r_seg_nib    <= req_i.segNibbles;
                r_seg_stride <= req_i.segStride;
                r_grp_stride <= req_i.grpStride;
                r_n_seg      <= req_i.nSeg;
                r_seg_base   <= req_i.baseAddr;
                r_grp_base   <= req_i.baseAddr;
                r_rmn_seg    <= req_i.nSeg;
                r_rmn_grp    <= req_i.nGrp;
            end
            if (w_hs) begin
                if (w_more_txn) begin
                    r_txn_cnt <= r_txn_cnt + TxnW'(1);
                end else if (r_rmn_seg != '0) begin
                    r_rmn_seg  <= r_rmn_seg - CntWidth'(1);
                    r_seg_base <= w_seg_next;
                end else if (r_rmn_grp != '0) begin
                    // New group restarts its segment walk at the new group base.
                    r_rmn_grp  <= r_rmn_grp - CntWidth'(1);
                    r_rmn_seg  <= r_n_seg;
                    r_grp_base <= w_grp_next;
                    r_seg_base <= w_grp_next;
                end
            end
            if (w_load_calc) begin
                r_txn_num <= w_txn_num;
                r_ltn     <= w_ltn;
                r_txn_cnt <= '0;
            end
        end
    end

    assign meta_glb_o.reqId          = r_req_id;
    assign meta_glb_o.isLoad         = r_is_load;
    assign meta_glb_o.rmnSeg         = r_rmn_seg;
    assign meta_glb_o.rmnGrp         = r_rmn_grp;
    assign meta_seglv_o.segBaseAddr  = r_seg_base;
    assign meta_seglv_o.txnCnt       = r_txn_cnt;
    assign meta_seglv_o.txnNum       = r_txn_num;
    assign meta_seglv_o.ltN          = r_ltn;

`ifndef SYNTHESIS
    a_seg_nibbles_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_accept |-> (req_i.segNibbles != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_vmeta_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmeta_ctrl_unit
// Description : Self-checking bench: directed table, stall/reset sequences and
//               random requests against a nested-loop reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmeta_ctrl_unit;
    import vlsu_pkg::*;

`ifdef VMETA_FAST_SEG_EN
    localparam int c_LAT = 1;
    localparam int c_SEG_GAP = 1;
`else
    localparam int c_LAT = 2;
    localparam int c_SEG_GAP = 2;
`endif

    typedef struct packed {
        logic [63:0] base;
        logic [3:0]  cnt;
        logic [3:0]  num;
        logic [13:0] ltn;
        logic [7:0]  rs;
        logic [7:0]  rg;
    } meta_exp_t;

    typedef struct packed {
        logic [63:0]         base;
        logic [15:0]         nib;
        logic [63:0]         sstr;
        logic [63:0]         gstr;
        logic [7:0]          ns;
        logic [7:0]          ng;
        logic [2:0]          n;
        meta_exp_t [3:0]     e;
    } dir_vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    vmeta_req_t  req_i = '0;
    logic        meta_valid_o;
    logic        meta_ready_i = 1'b0;
    meta_glb_t   meta_glb_o;
    meta_seglv_t meta_seglv_o;
    logic        busy_o;

    int n_checks = 0;
    int n_err = 0;
    meta_exp_t exp_q[$];
    dir_vec_t vecs[7];

    always #5 clk_i = ~clk_i;

    vmeta_ctrl_unit dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_i        (req_i),
        .meta_valid_o (meta_valid_o),
        .meta_ready_i (meta_ready_i),
        .meta_glb_o   (meta_glb_o),
        .meta_seglv_o (meta_seglv_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic meta_exp_t me(input logic [63:0] b, input int c, input int n,
                                     input int l, input int rs, input int rg);
        meta_exp_t m;
        m.base = b; m.cnt = 4'(c); m.num = 4'(n); m.ltn = 14'(l); m.rs = 8'(rs); m.rg = 8'(rg);
        return m;
    endfunction

    function automatic meta_exp_t dut_meta();
        meta_exp_t m;
        m.base = meta_seglv_o.segBaseAddr; m.cnt = meta_seglv_o.txnCnt;
        m.num = meta_seglv_o.txnNum; m.ltn = meta_seglv_o.ltN;
        m.rs = meta_glb_o.rmnSeg; m.rg = meta_glb_o.rmnGrp;
        return m;
    endfunction

    // Reference: enumerate groups, segments and pages directly from the request.
    task automatic model(input vmeta_req_t rq);
        logic [63:0] gb, sb;
        int off, endv, num;
        for (int g = 0; g <= int'(rq.nGrp); g++) begin
            gb = rq.baseAddr + 64'(g) * rq.grpStride;
            for (int s = 0; s <= int'(rq.nSeg); s++) begin
                sb   = gb + 64'(s) * rq.segStride;
                off  = int'(sb % 64'(PageNibbles));
                endv = off + int'(rq.segNibbles) - 1;
                num  = endv / PageNibbles;
                for (int t = 0; t <= num; t++)
                    exp_q.push_back(me(sb, t, num, (endv % PageNibbles) + 1,
                                       int'(rq.nSeg) - s, int'(rq.nGrp) - g));
            end
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_valid_i = 1'b0; meta_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
    endtask

    // mode 0: ready always high (timing checked); 1: random ready; 2: 5-cycle stall after first meta
    task automatic run_req(input vmeta_req_t rq, input int mode, input string tag);
        int cyc = 0, last_hs = 0, n_hs = 0, stall_left = 5;
        bit done = 0, stalled = 0, rdy;
        meta_exp_t act, snap, e;
        while (!req_ready_o && cyc < 50) begin @(negedge clk_i); cyc++; end
        if (!req_ready_o) begin
            chk(0, {tag, "_accept"}, "req_ready_o never rose");
            do_reset();
            return;
        end
        req_i = rq; req_valid_i = 1'b1; meta_ready_i = (mode == 0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 1;
        while (!done && cyc < 1500) begin
            act = dut_meta();
            if (stalled)
                chk(meta_valid_o && act == snap, {tag, "_stall_hold"},
                    $sformatf("got v=%0b %h required v=1 %h", meta_valid_o, act, snap));
            if (exp_q.size() != 0 && req_ready_o) begin
                chk(0, {tag, "_early_idle"}, $sformatf("idle with %0d metas outstanding", exp_q.size()));
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(n_hs == 1 && stall_left > 0 && meta_valid_o);
                    if (!rdy) stall_left--;
                end
            endcase
            meta_ready_i = rdy;
            stalled = 0;
            if (meta_valid_o && !rdy) begin
                stalled = 1; snap = act;
            end else if (meta_valid_o) begin
                e = exp_q.pop_front();
                chk(act == e && meta_glb_o.reqId == rq.reqId && meta_glb_o.isLoad == rq.isLoad,
                    {tag, "_meta"}, $sformatf("#%0d got %h id=%h ld=%b required %h id=%h ld=%b",
                    n_hs, act, meta_glb_o.reqId, meta_glb_o.isLoad, e, rq.reqId, rq.isLoad));
                if (mode == 0) begin
                    if (n_hs == 0)
                        chk(cyc == c_LAT, {tag, "_latency"}, $sformatf("got %0d required %0d", cyc, c_LAT));
                    else
                        chk(cyc - last_hs == ((e.cnt == 0) ? c_SEG_GAP : 1), {tag, "_gap"},
                            $sformatf("#%0d got %0d required %0d", n_hs, cyc - last_hs,
                                      (e.cnt == 0) ? c_SEG_GAP : 1));
                end
                last_hs = cyc; n_hs++;
                if (exp_q.size() == 0) done = 1;
            end
            @(negedge clk_i); cyc++;
        end
        meta_ready_i = 1'b0;
        if (!done) begin
            chk(0, {tag, "_complete"}, $sformatf("%0d metas missing", exp_q.size()));
            do_reset();
        end else begin
            chk(!meta_valid_o && req_ready_o && !busy_o, {tag, "_idle_after"},
                $sformatf("got v=%b rdy=%b busy=%b required 0 1 0", meta_valid_o, req_ready_o, busy_o));
        end
    endtask

    function automatic vmeta_req_t vec_req(input dir_vec_t v, input int id);
        vmeta_req_t r;
        r.reqId = 4'(id); r.isLoad = id[0]; r.baseAddr = v.base; r.segNibbles = v.nib;
        r.segStride = v.sstr; r.grpStride = v.gstr; r.nSeg = v.ns; r.nGrp = v.ng;
        return r;
    endfunction

    initial begin
        vmeta_req_t rq;
        bit saw_valid;
        int k;

        vecs[0] = '0; vecs[0].base = 64'h100; vecs[0].nib = 16'h40; vecs[0].n = 1;
        vecs[0].e[0] = me(64'h100, 0, 0, 'h140, 0, 0);
        vecs[1] = '0; vecs[1].base = 64'h1F00; vecs[1].nib = 16'h3000; vecs[1].n = 3;
        for (int i = 0; i < 3; i++) vecs[1].e[i] = me(64'h1F00, i, 2, 'hF00, 0, 0);
        vecs[2] = '0; vecs[2].base = 64'h10; vecs[2].nib = 16'h10; vecs[2].sstr = 64'h2000;
        vecs[2].ns = 2; vecs[2].n = 3;
        vecs[2].e[0] = me(64'h10, 0, 0, 'h20, 2, 0);
        vecs[2].e[1] = me(64'h2010, 0, 0, 'h20, 1, 0);
        vecs[2].e[2] = me(64'h4010, 0, 0, 'h20, 0, 0);
        vecs[3] = '0; vecs[3].nib = 16'h10; vecs[3].sstr = 64'h20; vecs[3].gstr = 64'h1000;
        vecs[3].ns = 1; vecs[3].ng = 1; vecs[3].n = 4;
        vecs[3].e[0] = me(64'h0, 0, 0, 'h10, 1, 1);
        vecs[3].e[1] = me(64'h20, 0, 0, 'h30, 0, 1);
        vecs[3].e[2] = me(64'h1000, 0, 0, 'h1010, 1, 0);
        vecs[3].e[3] = me(64'h1020, 0, 0, 'h1030, 0, 0);
        vecs[4] = '0; vecs[4].base = 64'hFFFF_FFFF_FFFF_F000; vecs[4].nib = 16'h10;
        vecs[4].sstr = 64'h2000; vecs[4].ns = 1; vecs[4].n = 2;
        vecs[4].e[0] = me(64'hFFFF_FFFF_FFFF_F000, 0, 0, 'h1010, 1, 0);
        vecs[4].e[1] = me(64'h1000, 0, 0, 'h1010, 0, 0);
        vecs[5] = '0; vecs[5].base = 64'h1FFF; vecs[5].nib = 16'h2; vecs[5].n = 2;
        vecs[5].e[0] = me(64'h1FFF, 0, 1, 'h1, 0, 0);
        vecs[5].e[1] = me(64'h1FFF, 1, 1, 'h1, 0, 0);
        vecs[6] = '0; vecs[6].base = 64'h4000; vecs[6].nib = 16'h2000; vecs[6].n = 1;
        vecs[6].e[0] = me(64'h4000, 0, 0, 'h2000, 0, 0);

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(negedge clk_i);
        chk(req_ready_o && !meta_valid_o && !busy_o && meta_glb_o == '0 && meta_seglv_o == '0,
            "reset_state", $sformatf("got rdy=%b v=%b busy=%b glb=%h seg=%h required 1 0 0 0 0",
            req_ready_o, meta_valid_o, busy_o, meta_glb_o, meta_seglv_o));
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++) exp_q.push_back(vecs[i].e[j]);
            run_req(vec_req(vecs[i], i + 1), 0, $sformatf("vec%0d", i));
        end

        // Stall for 5 cycles mid-request.
        for (int j = 0; j < 4; j++) exp_q.push_back(vecs[3].e[j]);
        run_req(vec_req(vecs[3], 9), 2, "stall");

        // Reset while EMIT is holding a meta.
        req_i = vec_req(vecs[1], 10); req_valid_i = 1'b1; meta_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 0;
        while (!meta_valid_o && k < 10) begin @(negedge clk_i); k++; end
        chk(meta_valid_o, "rst_pre_valid", $sformatf("got v=%b required 1", meta_valid_o));
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk(!meta_valid_o && req_ready_o && !busy_o, "rst_mid_emit",
            $sformatf("got v=%b rdy=%b busy=%b required 0 1 0", meta_valid_o, req_ready_o, busy_o));
        rst_ni = 1'b1;
        saw_valid = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (meta_valid_o || busy_o) saw_valid = 1;
        end
        chk(!saw_valid, "rst_no_partial", $sformatf("got activity=%b required 0", saw_valid));

        // Random requests against the reference model with random backpressure.
        for (int i = 0; i < 40; i++) begin
            rq.reqId = 4'($urandom); rq.isLoad = 1'($urandom);
            rq.baseAddr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rq.baseAddr[12:0] = 13'h1FFF - 13'($urandom_range(0, 15));
            rq.segNibbles = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 16'hFFFF))
                                                        : 16'($urandom_range(1, 16'h4000));
            rq.segStride = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 16'hFFFF));
            rq.grpStride = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 20'hFFFFF));
            rq.nSeg = 8'($urandom_range(0, 3));
            rq.nGrp = 8'($urandom_range(0, 2));
            model(rq);
            run_req(rq, 1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
